// File: rtl/block_transfer_unit.sv
// LDM/STM sequencer: walks reg_list low-to-high, one word transfer per set bit.
// Optional base-register writeback state is built only when BTU_WRITEBACK_EN is defined.
module block_transfer_unit #(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_load,
  input  logic                  up,
  input  logic                  pre,
  input  logic                  writeback,
  input  logic [ADDR_WIDTH-1:0] base_reg,
  input  logic [WORD_SIZE-1:0]  base_addr,
  input  logic [NUM_REGS-1:0]   reg_list,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr,
  input  logic [WORD_SIZE-1:0]  rf_rd_data,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [WORD_SIZE-1:0]  rf_wr_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [WORD_SIZE-1:0]  mem_addr,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  input  logic [WORD_SIZE-1:0]  mem_rdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  pc_loaded
);

  localparam int unsigned CNT_W = $clog2(NUM_REGS + 1);

  typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    is_load_q;
  logic [ADDR_WIDTH-1:0]   base_reg_q;
  logic [NUM_REGS-1:0]     list_q;
  logic [WORD_SIZE-1:0]    addr_q;
  logic [WORD_SIZE-1:0]    wb_val_q;
  logic [ADDR_WIDTH-1:0]   cur_idx_q;
  logic                    pc_loaded_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    mem_req_q;
  logic                    mem_we_q;
  logic [NUM_REGS-1:0]     list_rest_c;
  logic [WORD_SIZE-1:0]    four_n_c;
  logic [WORD_SIZE-1:0]    start_addr_c;
  logic                    accept_c;
  logic                    load_ack_c;
  logic                    in_wb_c;
  logic                    load_sel_c;
`ifdef BTU_WRITEBACK_EN
  logic                    wb_en_q;
`else
  logic                    unused_writeback;
  assign unused_writeback = writeback;
`endif

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
    popcount = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) popcount = popcount + CNT_W'(v[i]);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] lowest_idx(input logic [NUM_REGS-1:0] v);
    lowest_idx = '0;
    for (int i = int'(NUM_REGS) - 1; i >= 0; i--) if (v[i]) lowest_idx = ADDR_WIDTH'(i);
  endfunction

  // Start address: lowest register always maps to the lowest address.
  always_comb begin
    four_n_c     = WORD_SIZE'(popcount(reg_list)) << 2;
    start_addr_c = base_addr;
    case ({up, pre})
      2'b10:   start_addr_c = base_addr;
      2'b11:   start_addr_c = base_addr + WORD_SIZE'(4);
      2'b00:   start_addr_c = base_addr - four_n_c + WORD_SIZE'(4);
      default: start_addr_c = base_addr - four_n_c;
    endcase
  end

  assign accept_c    = (state_q == IDLE) && start;
  assign list_rest_c = list_q & (list_q - NUM_REGS'(1));
  assign load_ack_c  = (state_q == XFER) && is_load_q && mem_ack;
  assign in_wb_c     = (state_q == WB);
  assign load_sel_c  = (state_q == IDLE) ? is_load : is_load_q;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (reg_list == '0) ? DONE : XFER;
      XFER: if (mem_ack && (list_rest_c == '0)) begin
`ifdef BTU_WRITEBACK_EN
        state_d = wb_en_q ? WB : DONE;
`else
        state_d = DONE;
`endif
      end
      WB:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      is_load_q   <= 1'b0;
      base_reg_q  <= '0;
      list_q      <= '0;
      addr_q      <= '0;
      wb_val_q    <= '0;
      cur_idx_q   <= '0;
      pc_loaded_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
`ifdef BTU_WRITEBACK_EN
      wb_en_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      mem_req_q <= (state_d == XFER);
      mem_we_q  <= (state_d == XFER) && !load_sel_c;
      if (accept_c) begin
        is_load_q   <= is_load;
        base_reg_q  <= base_reg;
        list_q      <= reg_list;
        addr_q      <= start_addr_c;
        wb_val_q    <= up ? (base_addr + four_n_c) : (base_addr - four_n_c);
        cur_idx_q   <= lowest_idx(reg_list);
        pc_loaded_q <= 1'b0;
`ifdef BTU_WRITEBACK_EN
        // A base register reloaded by LDM keeps the loaded value.
        wb_en_q     <= writeback && !(is_load && reg_list[base_reg]);
`endif
      end else if ((state_q == XFER) && mem_ack) begin
        list_q    <= list_rest_c;
        addr_q    <= addr_q + WORD_SIZE'(4);
        cur_idx_q <= lowest_idx(list_rest_c);
        if (is_load_q && (cur_idx_q == ADDR_WIDTH'(15))) pc_loaded_q <= 1'b1;
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pc_loaded  = pc_loaded_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = addr_q;
  assign rf_rd_addr = cur_idx_q;
  // Store data and load write-back pass straight through in the transfer cycle.
  assign mem_wdata  = ((state_q == XFER) && !is_load_q) ? rf_rd_data : '0;
  assign rf_we      = load_ack_c || in_wb_c;
  assign rf_wr_addr = load_ack_c ? cur_idx_q : (in_wb_c ? base_reg_q : '0);
  assign rf_wr_data = load_ack_c ? mem_rdata : (in_wb_c ? wb_val_q : '0);

endmodule

// File: tb/tb_block_transfer_unit.sv
// Scoreboard bench for block_transfer_unit: directed LDM/STM vectors with hand-computed events.
module tb_block_transfer_unit;

  localparam logic [31:0] K = 32'hA5A5_0000;
  localparam int KMW = 0, KMR = 1, KRF = 2, KDN = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, is_load, up, pre, writeback;
  logic [3:0]  base_reg;
  logic [31:0] base_addr;
  logic [15:0] reg_list;
  logic [3:0]  rf_rd_addr, rf_wr_addr;
  logic [31:0] rf_rd_data, rf_wr_data;
  logic        rf_we, mem_req, mem_we, mem_ack, busy, done, pc_loaded;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
    int          cyc;
  } ev_t;

  ev_t  exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   ack_delay = 0;
  int   wait_cnt  = 0;
  bit   done_flag = 0;
  logic        prev_req = 1'b0, prev_ack = 1'b0;
  logic [31:0] prev_addr = '0;

  block_transfer_unit dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load), .up(up), .pre(pre),
    .writeback(writeback), .base_reg(base_reg), .base_addr(base_addr), .reg_list(reg_list),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .rf_we(rf_we), .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy),
    .done(done), .pc_loaded(pc_loaded)
  );

  always #5 clk = ~clk;

  // Register file holds 0x11*i; memory returns address ^ K.
  assign rf_rd_data = 32'(rf_rd_addr) * 32'h11;
  assign mem_rdata  = mem_addr ^ K;

  // Cycle index relative to the accepted start edge (cycle 1 follows edge 0).
  always @(posedge clk) begin
    if (start && !busy) cyc = 1;
    else cyc = cyc + 1;
  end

  // Memory responder: ack after ack_delay waiting cycles per transfer.
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      if (wait_cnt == ack_delay) begin mem_ack = 1'b1; wait_cnt = 0; end
      else begin mem_ack = 1'b0; wait_cnt = wait_cnt + 1; end
    end else begin
      mem_ack = 1'b0; wait_cnt = 0;
    end
  end

  function automatic void expect_ev(int kind, logic [31:0] a, logic [31:0] d, int c);
    ev_t e;
    e.kind = kind; e.a = a; e.d = d; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic observe(int kind, logic [31:0] a, logic [31:0] d);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected event: kind %0d a %h d %h cycle %0d", kind, a, d, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.a === a && e.d === d && e.cyc == cyc) n_pass++;
      else $display("FAIL event: got kind %0d a %h d %h cycle %0d, expected kind %0d a %h d %h cycle %0d",
                    kind, a, d, cyc, e.kind, e.a, e.d, e.cyc);
    end
  endtask

  // Monitor: samples on the falling edge, in mem -> rf -> done order.
  always @(negedge clk) begin
    if (mem_req && mem_ack) observe(mem_we ? KMW : KMR, mem_addr, mem_we ? mem_wdata : 32'h0);
    if (rf_we) observe(KRF, 32'(rf_wr_addr), rf_wr_data);
    if (done) begin
      done_flag = 1;
      observe(KDN, 32'h0, {30'b0, busy, pc_loaded});
    end
    if (reset && prev_req && !prev_ack)
      check("request held while waiting", {mem_req, mem_addr[30:0]}, {1'b1, prev_addr[30:0]});
    prev_req = mem_req; prev_ack = mem_ack; prev_addr = mem_addr;
  end

  task automatic issue(bit ld, bit u, bit p, bit wb, logic [3:0] br, logic [31:0] base,
                       logic [15:0] list, int hold);
    is_load = ld; up = u; pre = p; writeback = wb; base_reg = br;
    base_addr = base; reg_list = list; start = 1'b1; done_flag = 0;
    @(posedge clk);
    for (int i = 1; i < hold; i++) begin
      #1 base_addr = ~base; reg_list = ~list;
      @(posedge clk);
    end
    #1 start = 1'b0;
  endtask

  task automatic finish_op(string name);
    for (int i = 0; i < 60 && !done_flag; i++) @(posedge clk);
    if (!done_flag) begin
      n_checks++;
      $display("FAIL %s: timeout waiting for done", name);
    end
    repeat (2) @(posedge clk);
    #1 check({name, " events drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; is_load = 1'b0; up = 1'b0; pre = 1'b0; writeback = 1'b0;
    base_reg = '0; base_addr = '0; reg_list = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset mem_req/mem_we", {mem_req, mem_we}, 0);
    check("reset rf_we", 32'(rf_we), 0);
    check("reset pc_loaded", 32'(pc_loaded), 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset addrs", {rf_rd_addr, rf_wr_addr}, 0);
    check("reset data", rf_wr_data | mem_wdata, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // STM IA, start held 3 cycles with scrambled inputs (must be ignored while busy).
    ack_delay = 0;
    expect_ev(KMW, 32'h100, 32'h11, 1);
    expect_ev(KMW, 32'h104, 32'h22, 2);
    expect_ev(KMW, 32'h108, 32'h33, 3);
    expect_ev(KDN, 0, 32'h2, 4);
    issue(0, 1, 0, 0, 4'd0, 32'h100, 16'h000E, 3);
    finish_op("stm_ia");

    // LDM DB with writeback, R15 in list.
    expect_ev(KMR, 32'h1F8, 0, 1);
    expect_ev(KRF, 32'd0, 32'h1F8 ^ K, 1);
    expect_ev(KMR, 32'h1FC, 0, 2);
    expect_ev(KRF, 32'd15, 32'h1FC ^ K, 2);
`ifdef BTU_WRITEBACK_EN
    expect_ev(KRF, 32'd13, 32'h1F8, 3);
    expect_ev(KDN, 0, 32'h3, 4);
`else
    expect_ev(KDN, 0, 32'h3, 3);
`endif
    @(posedge clk); #1;
    issue(1, 0, 1, 1, 4'd13, 32'h200, 16'h8001, 1);
    finish_op("ldm_db_wb");

    // LDM IB, ack 3 cycles late per transfer.
    ack_delay = 3;
    expect_ev(KMR, 32'h304, 0, 4);
    expect_ev(KRF, 32'd4, 32'h304 ^ K, 4);
    expect_ev(KMR, 32'h308, 0, 8);
    expect_ev(KRF, 32'd5, 32'h308 ^ K, 8);
    expect_ev(KDN, 0, 32'h2, 9);
    @(posedge clk); #1;
    issue(1, 1, 1, 0, 4'd9, 32'h300, 16'h0030, 1);
    finish_op("ldm_ib_slow");
    ack_delay = 0;

    // LDM IA with base in list: loaded value wins, no writeback.
    expect_ev(KMR, 32'h400, 0, 1);
    expect_ev(KRF, 32'd1, 32'h400 ^ K, 1);
    expect_ev(KMR, 32'h404, 0, 2);
    expect_ev(KRF, 32'd2, 32'h404 ^ K, 2);
    expect_ev(KDN, 0, 32'h2, 3);
    @(posedge clk); #1;
    issue(1, 1, 0, 1, 4'd2, 32'h400, 16'h0006, 1);
    finish_op("ldm_base_in_list");

    // Empty list with writeback requested.
    expect_ev(KDN, 0, 32'h2, 1);
    @(posedge clk); #1;
    issue(1, 1, 0, 1, 4'd3, 32'h480, 16'h0000, 1);
    finish_op("empty_list");

    // STM DA aborted by reset during the 2nd transfer.
    expect_ev(KMW, 32'h4F4, 32'h44, 1);
    @(posedge clk); #1;
    issue(0, 0, 0, 1, 4'd8, 32'h500, 16'h00F0, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort busy", 32'(busy), 0);
    check("abort mem_req", 32'(mem_req), 0);
    check("abort rf_we", 32'(rf_we), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort no done", 32'(done_flag), 0);
    check("abort events drained", 32'(exp_q.size()), 0);

    // STM DB with writeback after the abort.
    expect_ev(KMW, 32'h5F8, 32'h00, 1);
    expect_ev(KMW, 32'h5FC, 32'h11, 2);
`ifdef BTU_WRITEBACK_EN
    expect_ev(KRF, 32'd3, 32'h5F8, 3);
    expect_ev(KDN, 0, 32'h2, 4);
`else
    expect_ev(KDN, 0, 32'h2, 3);
`endif
    issue(0, 0, 1, 1, 4'd3, 32'h600, 16'h0003, 1);
    finish_op("stm_db_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/block_transfer_unit.md
# block_transfer_unit

Multi-cycle sequencer for ARM load/store-multiple instructions (LDM/STM). On `start` it walks the 16-bit register list in ascending order. For each set bit it issues one word transfer on the data-memory port, using the register-file port as the other end of the transfer:
- stores read the register and write the word to memory;
- loads write the memory word back into the register.

It sits between the decode/control unit and the register file/data memory, and owns the register-file ports while `busy` is high.

## Interface
Parameters:
- `WORD_SIZE`, 32, data/address width
- `NUM_REGS`, 16, register count; width of `reg_list`
- `ADDR_WIDTH`, 4, register index width

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (asserts immediately, releases synchronously to `clk`)
- `start`  in  1  begin operation; sampled only when `busy`=0
- `is_load`  in  1  1=LDM, 0=STM
- `up`  in  1  U bit: 1=increment, 0=decrement
- `pre`  in  1  P bit: 1=before, 0=after
- `writeback`  in  1  W bit
- `base_reg`  in  ADDR_WIDTH  base register index
- `base_addr`  in  WORD_SIZE  base register value
- `reg_list`  in  NUM_REGS  register list
- `rf_rd_addr`  out  ADDR_WIDTH  register read index
- `rf_rd_data`  in  WORD_SIZE  combinational read data
- `rf_we`  out  1  register write enable
- `rf_wr_addr`  out  ADDR_WIDTH  register write index
- `rf_wr_data`  out  WORD_SIZE  register write data
- `mem_req`  out  1  memory request
- `mem_we`  out  1  1=store
- `mem_addr`  out  WORD_SIZE  word address
- `mem_wdata`  out  WORD_SIZE  store data
- `mem_rdata`  in  WORD_SIZE  load data, valid with `mem_ack`
- `mem_ack`  in  1  transfer complete
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle completion pulse
- `pc_loaded`  out  1  R15 was written by this LDM; valid with `done`

## Operation
- States:
  - IDLE → XFER on `start`, when `reg_list`≠0.
  - IDLE → DONE on `start`, when `reg_list`=0. No memory access and no writeback for an empty list.
  - XFER → XFER on `mem_ack`, while registers remain.
  - XFER → WB after the last `mem_ack`, when writeback is enabled (see the base-in-list rule below).
  - XFER → DONE after the last `mem_ack` otherwise.
  - WB → DONE.
  - DONE → IDLE.
- At `start`, latch all inputs. Compute `n` = popcount(`reg_list`) (0..16). Compute the start address:
  - IA (`up`=1,`pre`=0): base
  - IB (`up`=1,`pre`=1): base+4
  - DA (`up`=0,`pre`=0): base−4n+4
  - DB (`up`=0,`pre`=1): base−4n
- The lowest set register goes to the lowest address. The address increments by 4 per transfer. All arithmetic is modulo 2^WORD_SIZE.
- XFER:
  - `mem_req`=1 and `mem_we`=!`is_load`.
  - `mem_addr` is the current address.
  - `rf_rd_addr` is the current register index; `mem_wdata`=`rf_rd_data`.
  - Request signals stay stable until `mem_ack`.
- Load, in the `mem_ack` cycle:
  - `rf_we`=1, `rf_wr_addr`=current register, `rf_wr_data`=`mem_rdata`.
  - `pc_loaded` is set if the register is 15.
- WB: `rf_we`=1, `rf_wr_addr`=`base_reg`, `rf_wr_data`=base+4n (`up`=1) or base−4n (`up`=0).
- Base register in the list with `is_load`=1: the loaded value wins and WB is skipped. With `is_load`=0, STM stores the original base value.
- Outside XFER and WB: `rf_we`=0 and `mem_req`=0.

## Timing
- Reset values: state IDLE. `busy`, `done`, `pc_loaded`, `mem_req`, `mem_we`, `rf_we`=0. All address and data outputs are 0.
- Operation sequence:
  - `start` is sampled at edge 0.
  - `busy`=1 and the first `mem_req` appear in cycle 1.
  - Each transfer takes ≥1 cycle; with `mem_ack` tied high, one register per cycle.
  - With `mem_ack` high, n registers and WB: XFER occupies cycles 1..n, WB is cycle n+1, `done`=1 in cycle n+2.
  - Without WB, `done`=1 in cycle n+1.
  - Empty list: `done` in cycle 1.
- `busy` is high from cycle 1 through the DONE cycle inclusive. `start` is ignored while `busy`=1.
- `mem_ack` outside XFER is ignored.
- `reset` asserted mid-operation:
  - all outputs return to their reset values immediately;
  - no further register or memory writes occur;
  - no `done` pulse is produced.

## Configuration
- `BTU_WRITEBACK_EN` defined: WB state is present and `writeback`=1 updates the base register as specified.
- `BTU_WRITEBACK_EN` undefined: the WB state is removed and `writeback` is ignored. `done` always follows the last transfer by one cycle.

## Test plan
- STM IA, base=0x100, list=0x000E (R1–R3 = 0x11,0x22,0x33), `mem_ack` tied 1 → stores 0x11@0x100, 0x22@0x104, 0x33@0x108 in cycles 1–3; `done` in cycle 4.
- LDM DB, base=0x200, list=0x8001, W=1, `mem_ack` tied 1 → R0←mem[0x1F8], R15←mem[0x1FC]. WB base←0x1F8 in cycle 3, `done` in cycle 4, `pc_loaded`=1.
- LDM IB, `mem_ack` delayed 3 cycles per transfer → `mem_addr`/`mem_req` held stable while waiting. Exactly one `rf_we` per ack, with addresses base+4 and base+8.
- LDM, list includes `base_reg`, W=1 → base holds the loaded value; no WB write occurs.
- Empty list, W=1 → `done` in cycle 1; no `mem_req`, no `rf_we`.
- `reset` low during the 2nd transfer → `busy`, `mem_req`, `rf_we` drop immediately. No `done` pulse; the next `start` behaves normally.
